// File: rtl/ifetch_queue_if.sv
// Head-of-queue handshake toward ID: valid/ready plus the {pc, instr, exccode} entry.
interface ifetch_queue_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  out_exccode;

  modport master (output out_valid, out_pc, out_instr, out_exccode, input out_ready);
  modport slave  (input out_valid, out_pc, out_instr, out_exccode, output out_ready);
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: PC/fetch FSM feeding a DEPTH-entry FIFO toward ID.
// Optional macro IFQ_BYPASS_EN: an empty queue forwards the current fetch combinationally.
module ifetch_queue #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_4FFF
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     flush,
  input  logic                     epc_we,
  input  logic [31:0]              epc_value,
  ifetch_queue_if.master           deq,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {FETCH, HOLD} state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   cnt;
  logic [31:0]     q_pc    [DEPTH];
  logic [31:0]     q_instr [DEPTH];
  logic [4:0]      q_exc   [DEPTH];

  logic        fault, ctrl, full, pop_q, push, push_q, take_byp;
  logic [31:0] f_instr;
  logic [4:0]  f_exc;

  assign imem_addr = pc;
  assign count     = cnt;
  assign fault     = (pc[1:0] != 2'b00) || (pc < TEXT_LO) || (pc > TEXT_HI);
  assign f_instr   = fault ? 32'h0 : imem_rdata;
  assign f_exc     = fault ? 5'd4 : 5'd0;
  assign ctrl      = epc_we || flush || redirect;
  assign full      = (cnt == CW'(DEPTH));
  assign pop_q     = (cnt != '0) && deq.out_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push      = (state == FETCH) && !ctrl && (!full || pop_q);

`ifdef IFQ_BYPASS_EN
  logic byp;
  assign byp      = (cnt == '0) && (state == FETCH) && !ctrl && !reset;
  assign take_byp = byp && deq.out_ready;
`else
  assign take_byp = 1'b0;
`endif
  assign push_q = push && !take_byp;

  always_comb begin
    deq.out_valid   = 1'b0;
    deq.out_pc      = 32'h0;
    deq.out_instr   = 32'h0;
    deq.out_exccode = 5'd0;
    if (cnt != '0) begin
      deq.out_valid   = 1'b1;
      deq.out_pc      = q_pc[rptr];
      deq.out_instr   = q_instr[rptr];
      deq.out_exccode = q_exc[rptr];
    end
`ifdef IFQ_BYPASS_EN
    else if (byp) begin
      deq.out_valid   = 1'b1;
      deq.out_pc      = pc;
      deq.out_instr   = f_instr;
      deq.out_exccode = f_exc;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
    end else if (ctrl) begin
      // Control events discard everything queued, including a concurrent pop.
      state <= FETCH;
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      if (epc_we)     pc <= epc_value;
      else if (flush) pc <= HANDLER_PC;
      else            pc <= redirect_pc;
    end else begin
      if (push) begin
        pc <= pc + 32'd4;
        if (fault) state <= HOLD;
      end
      if (push_q) wptr <= wptr + AW'(1);
      if (pop_q)  rptr <= rptr + AW'(1);
      cnt <= cnt + CW'(push_q) - CW'(pop_q);
    end
  end

  always_ff @(posedge clk) begin
    if (push_q) begin
      q_pc[wptr]    <= pc;
      q_instr[wptr] <= f_instr;
      q_exc[wptr]   <= f_exc;
    end
  end
endmodule
